// File: rtl/ula_mult_seq_if.sv
// Bundle between a requester, the ula_mult_seq controller and the 4-bit ALU it drives.
// The slave modport is the controller's view; the master modport is the surrounding datapath's view.
interface ula_mult_seq_if;
    logic       inicio;
    logic [3:0] mult_a;
    logic [3:0] mult_b;
    logic [3:0] ula_res;
    logic       ula_cout;
    logic [3:0] ula_a;
    logic [3:0] ula_b;
    logic       ula_cin;
    logic [2:0] ula_sel;
    logic [7:0] produto;
    logic       pronto;
    logic       ocupado;

    modport slave (
        input  inicio, mult_a, mult_b, ula_res, ula_cout,
        output ula_a, ula_b, ula_cin, ula_sel, produto, pronto, ocupado
    );

    modport master (
        output inicio, mult_a, mult_b, ula_res, ula_cout,
        input  ula_a, ula_b, ula_cin, ula_sel, produto, pronto, ocupado
    );
endinterface

// File: rtl/ula_mult_seq.sv
// Sequential 4x4 unsigned shift-and-add multiplier that borrows the shared 4-bit ALU
// for every add and every right shift of the partial product.
module ula_mult_seq #(
    parameter bit PULAR_ZERO = 1'b1
) (
    input logic          clk,
    input logic          rst_n,
    ula_mult_seq_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ADD, SHIFT, DONE} state_t;

    localparam logic [2:0] SEL_AND = 3'b000;
    localparam logic [2:0] SEL_ADD = 3'b100;
    localparam logic [2:0] SEL_SHR = 3'b111;

    state_t     state_q, state_d;
    logic [3:0] m_q, m_d;
    logic [3:0] ph_q, ph_d;
    logic [3:0] pl_q, pl_d;
    logic       c_q, c_d;
    logic [1:0] cnt_q, cnt_d;
    logic [7:0] produto_q, produto_d;

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the values from before the edge regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            m_q       <= '0;
            ph_q      <= '0;
            pl_q      <= '0;
            c_q       <= 1'b0;
            cnt_q     <= '0;
            produto_q <= '0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            ph_q      <= ph_d;
            pl_q      <= pl_d;
            c_q       <= c_d;
            cnt_q     <= cnt_d;
            produto_q <= produto_d;
        end
    end

    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        m_d         = m_q;
        ph_d        = ph_q;
        pl_d        = pl_q;
        c_d         = c_q;
        cnt_d       = cnt_q;
        produto_d   = produto_q;
        bus.ula_sel = SEL_AND;
        bus.ula_a   = '0;
        bus.ula_b   = '0;
        bus.pronto  = 1'b0;
        bus.ocupado = 1'b1;

        unique case (state_q)
            IDLE: begin
                bus.ocupado = 1'b0;
                if (bus.inicio) begin
                    m_d     = bus.mult_a;
                    pl_d    = bus.mult_b;
                    ph_d    = '0;
                    c_d     = 1'b0;
                    cnt_d   = '0;
                    state_d = (!PULAR_ZERO || bus.mult_b[0]) ? ADD : SHIFT;
                end
            end
            ADD: begin
                bus.ula_sel = SEL_ADD;
                bus.ula_a   = ph_q;
                bus.ula_b   = pl_q[0] ? m_q : 4'd0;
                {c_d, ph_d} = {bus.ula_cout, bus.ula_res};
                state_d     = SHIFT;
            end
            SHIFT: begin
                // The ALU shifts PH right; the add carry refills its top bit and
                // PH[0] drops into PL as the next settled product bit.
                bus.ula_sel = SEL_SHR;
                bus.ula_a   = ph_q;
                ph_d        = {c_q, bus.ula_res[2:0]};
                pl_d        = {ph_q[0], pl_q[3:1]};
                c_d         = 1'b0;
                cnt_d       = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    state_d = DONE;
                end else begin
                    state_d = (!PULAR_ZERO || pl_q[1]) ? ADD : SHIFT;
                end
            end
            DONE: begin
                bus.pronto = 1'b1;
                produto_d  = {ph_q, pl_q};
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.ula_cin = 1'b0;
    assign bus.produto = produto_q;

endmodule

// File: tb/tb_ula_mult_seq.sv
// Self-checking bench: both PULAR_ZERO variants run beside a behavioural ALU model,
// with directed scenarios, an exhaustive operand sweep and random jobs.
module tb_ula_mult_seq;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ula_mult_seq_if bus0 ();
    ula_mult_seq_if bus1 ();

    ula_mult_seq #(.PULAR_ZERO(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
    ula_mult_seq #(.PULAR_ZERO(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

    logic       cur;
    logic       inicio_v;
    logic [3:0] a_v, b_v;

    assign bus0.inicio = inicio_v & ~cur;
    assign bus1.inicio = inicio_v & cur;
    assign bus0.mult_a = a_v;
    assign bus0.mult_b = b_v;
    assign bus1.mult_a = a_v;
    assign bus1.mult_b = b_v;

    function automatic logic [4:0] alu(input logic [2:0] s, input logic [3:0] a, input logic [3:0] b,
                                       input logic cin);
        case (s)
            3'b100:  return {1'b0, a} + {1'b0, b} + {4'd0, cin};
            3'b111:  return {2'b00, a[3:1]};
            3'b000:  return {1'b0, a & b};
            default: return 5'd0;
        endcase
    endfunction

    assign {bus0.ula_cout, bus0.ula_res} = alu(bus0.ula_sel, bus0.ula_a, bus0.ula_b, bus0.ula_cin);
    assign {bus1.ula_cout, bus1.ula_res} = alu(bus1.ula_sel, bus1.ula_a, bus1.ula_b, bus1.ula_cin);

    logic [7:0] o_produto;
    logic       o_pronto, o_ocupado;
    logic [2:0] o_sel;
    logic [3:0] o_a, o_b;
    assign o_produto = cur ? bus1.produto : bus0.produto;
    assign o_pronto  = cur ? bus1.pronto  : bus0.pronto;
    assign o_ocupado = cur ? bus1.ocupado : bus0.ocupado;
    assign o_sel     = cur ? bus1.ula_sel : bus0.ula_sel;
    assign o_a       = cur ? bus1.ula_a   : bus0.ula_a;
    assign o_b       = cur ? bus1.ula_b   : bus0.ula_b;

    logic cin_bad = 1'b0;
    always @(negedge clk) if (bus0.ula_cin !== 1'b0 || bus1.ula_cin !== 1'b0) cin_bad = 1'b1;

    int total = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: one ADD per processed multiplier bit (every bit when not skipping), one SHIFT per bit.
    function automatic logic [47:0] exp_seq(input bit pz, input logic [3:0] b);
        logic [47:0] s = '0;
        for (int i = 0; i < 4; i++) begin
            if (!pz || b[i]) s = {s[44:0], 3'b100};
            s = {s[44:0], 3'b111};
        end
        return s;
    endfunction

    function automatic int exp_lat(input bit pz, input logic [3:0] b);
        return pz ? 5 + $countones(b) : 9;
    endfunction

    task automatic start(input bit pz, input logic [3:0] a, input logic [3:0] b, input bit hold);
        int guard = 0;
        @(negedge clk);
        cur = pz;
        #1;
        while (o_ocupado && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        a_v = a;
        b_v = b;
        inicio_v = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) inicio_v = 1'b0;
    endtask

    // Counts cycles after the accepting edge until pronto; n stays 0 on timeout.
    task automatic wait_done(output int n, output logic [47:0] seq);
        bit found = 1'b0;
        n = 0;
        seq = '0;
        for (int i = 1; i <= 20 && !found; i++) begin
            @(negedge clk);
            if (o_pronto) begin
                n = i;
                found = 1'b1;
            end else begin
                seq = {seq[44:0], o_sel};
            end
        end
    endtask

    task automatic run_job(input bit pz, input logic [3:0] a, input logic [3:0] b, input string tag);
        int n;
        logic [47:0] seq;
        start(pz, a, b, 1'b0);
        wait_done(n, seq);
        check({tag, "_lat"}, 48'(n), 48'(exp_lat(pz, b)));
        check({tag, "_seq"}, seq, exp_seq(pz, b));
        @(negedge clk);
        check({tag, "_pulse"}, 48'(o_pronto), 48'd0);
        check({tag, "_prod"}, 48'(o_produto), 48'(int'(a) * int'(b)));
    endtask

    initial begin
        int n, pc;
        logic [47:0] seq;

        rst_n = 1'b0;
        cur = 1'b0;
        inicio_v = 1'b0;
        a_v = '0;
        b_v = '0;
        #12;
        for (int p = 0; p < 2; p++) begin
            cur = p[0];
            #1;
            check("rst_prod", 48'(o_produto), 48'd0);
            check("rst_pronto", 48'(o_pronto), 48'd0);
            check("rst_ocup", 48'(o_ocupado), 48'd0);
            check("rst_sel", 48'(o_sel), 48'd0);
            check("rst_ab", 48'({o_a, o_b}), 48'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        run_job(1'b0, 4'hF, 4'hF, "pz0_FxF");
        run_job(1'b1, 4'hD, 4'hB, "pz1_DxB");
        run_job(1'b1, 4'hA, 4'h0, "pz1_Ax0");
        run_job(1'b1, 4'h0, 4'h5, "pz1_0x5");

        // A second inicio in the middle of a job must neither restart nor queue.
        start(1'b0, 4'h6, 4'h7, 1'b0);
        pc = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (o_pronto) pc++;
            if (i == 2) begin
                a_v = 4'hF;
                b_v = 4'hF;
                inicio_v = 1'b1;
            end
            if (i == 3) inicio_v = 1'b0;
        end
        check("ign_pronto_cnt", 48'(pc), 48'd1);
        check("ign_prod", 48'(o_produto), 48'h2A);

        // inicio held high across two jobs.
        start(1'b1, 4'h3, 4'h5, 1'b1);
        wait_done(n, seq);
        check("b2b_lat1", 48'(n), 48'd7);
        a_v = 4'h4;
        b_v = 4'h4;
        @(negedge clk);
        check("b2b_idle", 48'(o_ocupado), 48'd0);
        check("b2b_prod1", 48'(o_produto), 48'h0F);
        @(posedge clk);
        #1;
        inicio_v = 1'b0;
        wait_done(n, seq);
        check("b2b_lat2", 48'(n), 48'd6);
        @(negedge clk);
        check("b2b_prod2", 48'(o_produto), 48'h10);

        // Asynchronous reset during a SHIFT aborts the job with no pronto.
        start(1'b1, 4'h7, 4'h9, 1'b0);
        for (int i = 0; i < 4 && o_sel != 3'b111; i++) @(negedge clk);
        check("abort_in_shift", 48'(o_sel), 48'h7);
        rst_n = 1'b0;
        #1;
        check("abort_prod", 48'(o_produto), 48'd0);
        check("abort_pronto", 48'(o_pronto), 48'd0);
        check("abort_ocup", 48'(o_ocupado), 48'd0);
        check("abort_sel", 48'(o_sel), 48'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pc = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (o_pronto || o_ocupado) pc++;
        end
        check("abort_quiet", 48'(pc), 48'd0);
        check("abort_prod_hold", 48'(o_produto), 48'd0);

        for (int p = 0; p < 2; p++)
            for (int a = 0; a < 16; a++)
                for (int b = 0; b < 16; b++)
                    run_job(p[0], a[3:0], b[3:0], "sweep");

        for (int i = 0; i < 40; i++)
            run_job(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), "rand");

        check("cin_zero", 48'(cin_bad), 48'd0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
